// File: rtl/skolem_xnor_seq.sv
// Bit-serial xnor-implies Skolem evaluator: one XNOR fold per cycle over x then y.
// Optional reference checker enabled by defining SKOLEM_CHECK_EN.
module skolem_xnor_seq #(
  parameter int NX = 6,
  parameter int NY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NX-1:0]        x_in,
  input  logic [(1<<NX)-1:0]   tt_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NY-1:0]        y_out,
  output logic                 busy,
  output logic [15:0]          n_done,
  output logic                 chk_err
);

  localparam int F  = NX + NY - 2;
  localparam int CW = $clog2(NX + NY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [NX-1:0]   x_q, x_d;
  logic [NY-1:0]   y_q, y_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     n_done_q, n_done_d;
  logic            fold_bit, acc_next, handshake;

  function automatic logic f_xnor(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

  always_comb begin
    handshake = (state_q == DONE) && out_ready;
    // cnt selects the next operand: x[1..NX-1] first, then y[0..NY-2]
    fold_bit = 1'b0;
    for (int i = 0; i < NX; i++)
      if (cnt_q == CW'(i)) fold_bit = x_q[i];
    for (int k = 0; k < NY - 1; k++)
      if (cnt_q == CW'(NX + k)) fold_bit = y_q[k];
    acc_next = f_xnor(acc_q, fold_bit);

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    n_done_d = n_done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          x_d     = x_in;
          y_d     = '0;
          y_d[0]  = tt_in[x_in];
          acc_d   = x_in[0];
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        for (int k = 0; k < NY - 1; k++)
          if (cnt_q == CW'(NX + k)) y_d[k+1] = acc_next;
        if (cnt_q == CW'(F)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (n_done_q != 16'hFFFF) n_done_d = n_done_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      n_done_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      n_done_q <= n_done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign y_out     = y_q;
  assign n_done    = n_done_q;

`ifdef SKOLEM_CHECK_EN
  logic [NY-1:0] ref_y;
  logic          par;
  logic          chk_err_q;

  // Closed form: y[j] = parity(x, y[0..j-1]) ^ ((NX+j-1) mod 2)
  always_comb begin
    ref_y    = '0;
    ref_y[0] = y_q[0];
    par      = (^x_q) ^ y_q[0];
    for (int j = 1; j < NY; j++) begin
      ref_y[j] = par ^ (((NX + j - 1) % 2) != 0);
      par      = par ^ ref_y[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             chk_err_q <= 1'b0;
    else if (handshake && (y_q != ref_y)) chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
